// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares the single-port, byte-addressed data memory between the pipeline
//   MEM stage (port 0) and the debug/program-loader port (port 1).
//
//   A request is accepted with a valid/ready handshake while the block is idle
//   or delivering a response. The accepted request is latched, drives the
//   memory for exactly one ACCESS cycle, and its result is returned as a
//   one-cycle pulse in the following RESP cycle. Misaligned or illegal-size
//   requests are flagged as errors and never write memory.
//
//   Port 0 wins by default. Port 1 wins when port 0 is idle or after it has
//   been held off for MAX_WAIT accepting cycles in a row.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   pN_req / pN_ready   request valid / request accepted this cycle
//   pN_addr, pN_wdata   byte address, store data
//   pN_we               1 = store, 0 = load
//   pN_size             00 byte, 01 half, 10 word, 11 illegal
//   pN_unsigned         zero-extend loads
//   pN_rsp_valid        one-cycle response pulse
//   pN_rdata, pN_rsp_err  load result (0 for stores/errors), error flag
//   mem_*               memory request, driven only during ACCESS
//   mem_read_data       combinational read data from memory
// -----------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int MAX_WAIT = 4,
   parameter int ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              p0_req,
   output logic              p0_ready,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [31:0]       p0_wdata,
   input  logic              p0_we,
   input  logic [1:0]        p0_size,
   input  logic              p0_unsigned,
   output logic              p0_rsp_valid,
   output logic [31:0]       p0_rdata,
   output logic              p0_rsp_err,

   input  logic              p1_req,
   output logic              p1_ready,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [31:0]       p1_wdata,
   input  logic              p1_we,
   input  logic [1:0]        p1_size,
   input  logic              p1_unsigned,
   output logic              p1_rsp_valid,
   output logic [31:0]       p1_rdata,
   output logic              p1_rsp_err,

   output logic [31:0]       mem_read_addr,
   output logic [31:0]       mem_write_addr,
   output logic [31:0]       mem_write_data,
   output logic              mem_write_enable,
   output logic [1:0]        mem_size,
   output logic              mem_is_unsigned,
   input  logic [31:0]       mem_read_data
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;

   localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

   logic [1:0]        state;
   logic [3:0]        wait_cnt;
   logic              owner;

   // Latched request
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic              we_q;
   logic [1:0]        size_q;
   logic              unsigned_q;

   // Per-port response registers; they hold until that port's next response
   logic [31:0]       p0_rdata_q;
   logic [31:0]       p1_rdata_q;
   logic              p0_err_q;
   logic              p1_err_q;

   logic              accepting;
   logic              grant1;
   logic              accept;
   logic              legal;
   logic              in_access;
   logic [31:0]       addr_ext;

   assign addr_ext  = 32'(addr_q);
   assign in_access = (state == ACCESS);

   // Port 1 only takes the grant when it is actually requesting, so a
   // saturated wait count never stalls a lone port 0 request.
   // NOTE: every signal assigned in an always_comb gets a value on every path
   // (here by construction, elsewhere by a default first) so no latch is inferred.
   always_comb begin
      accepting = (state == IDLE) || (state == RESP);
      grant1    = p1_req && (!p0_req || (wait_cnt == WAIT_MAX));
      p1_ready  = accepting && grant1;
      p0_ready  = accepting && p0_req && !grant1;
      accept    = p0_ready || p1_ready;
   end

   // Alignment check on the latched request
   always_comb begin
      case (size_q)
         2'b00:   legal = 1'b1;
         2'b01:   legal = !addr_q[0];
         2'b10:   legal = (addr_q[1:0] == 2'b00);
         default: legal = 1'b0;
      endcase
   end

   // Memory bus is quiet outside ACCESS; being decoded from state, the write
   // enable drops the instant reset is asserted.
   always_comb begin
      mem_read_addr    = '0;
      mem_write_addr   = '0;
      mem_write_data   = '0;
      mem_write_enable = 1'b0;
      mem_size         = '0;
      mem_is_unsigned  = 1'b0;
      if (in_access) begin
         mem_read_addr    = addr_ext;
         mem_write_addr   = addr_ext;
         mem_write_data   = wdata_q;
         mem_write_enable = we_q && legal;
         mem_size         = size_q;
         mem_is_unsigned  = unsigned_q;
      end
   end

   assign p0_rsp_valid = (state == RESP) && !owner;
   assign p1_rsp_valid = (state == RESP) &&  owner;
   assign p0_rdata     = p0_rdata_q;
   assign p1_rdata     = p1_rdata_q;
   assign p0_rsp_err   = p0_err_q;
   assign p1_rsp_err   = p1_err_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         owner      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         size_q     <= '0;
         unsigned_q <= 1'b0;
         p0_rdata_q <= '0;
         p1_rdata_q <= '0;
         p0_err_q   <= 1'b0;
         p1_err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE, RESP: state <= accept ? ACCESS : IDLE;
            ACCESS:     state <= RESP;
            default:    state <= IDLE;
         endcase

         if (accept) begin
            owner      <= p1_ready;
            addr_q     <= p1_ready ? p1_addr     : p0_addr;
            wdata_q    <= p1_ready ? p1_wdata    : p0_wdata;
            we_q       <= p1_ready ? p1_we       : p0_we;
            size_q     <= p1_ready ? p1_size     : p0_size;
            unsigned_q <= p1_ready ? p1_unsigned : p0_unsigned;
         end

         // Capture at the end of ACCESS into the owner's response registers
         if (in_access) begin
            if (owner) begin
               p1_rdata_q <= (legal && !we_q) ? mem_read_data : 32'h0;
               p1_err_q   <= !legal;
            end else begin
               p0_rdata_q <= (legal && !we_q) ? mem_read_data : 32'h0;
               p0_err_q   <= !legal;
            end
         end

         // Starvation counter: counts accepting cycles port 1 loses to port 0
         if (!p1_req || p1_ready) begin
            wait_cnt <= '0;
         end else if (p0_ready && (wait_cnt != WAIT_MAX)) begin
            wait_cnt <= wait_cnt + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Self-checking bench for dmem_arbiter. A byte-array memory answers the DUT's
//   memory bus. A transaction-level model (cycle numbers of the last accept,
//   a reference memory, a starvation counter) predicts ready, response and
//   memory-bus values every cycle; directed tests add literal expectations.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

   localparam int MAX_WAIT = 4;

   logic        clk = 1'b0;
   logic        rst;

   logic        p0_req, p0_ready, p0_we, p0_unsigned, p0_rsp_valid, p0_rsp_err;
   logic [31:0] p0_addr, p0_wdata, p0_rdata;
   logic [1:0]  p0_size;
   logic        p1_req, p1_ready, p1_we, p1_unsigned, p1_rsp_valid, p1_rsp_err;
   logic [31:0] p1_addr, p1_wdata, p1_rdata;
   logic [1:0]  p1_size;
   logic [31:0] mem_read_addr, mem_write_addr, mem_write_data, mem_read_data;
   logic        mem_write_enable, mem_is_unsigned;
   logic [1:0]  mem_size;

   dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_ready(p0_ready), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_we(p0_we), .p0_size(p0_size), .p0_unsigned(p0_unsigned),
      .p0_rsp_valid(p0_rsp_valid), .p0_rdata(p0_rdata), .p0_rsp_err(p0_rsp_err),
      .p1_req(p1_req), .p1_ready(p1_ready), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_we(p1_we), .p1_size(p1_size), .p1_unsigned(p1_unsigned),
      .p1_rsp_valid(p1_rsp_valid), .p1_rdata(p1_rdata), .p1_rsp_err(p1_rsp_err),
      .mem_read_addr(mem_read_addr), .mem_write_addr(mem_write_addr),
      .mem_write_data(mem_write_data), .mem_write_enable(mem_write_enable),
      .mem_size(mem_size), .mem_is_unsigned(mem_is_unsigned),
      .mem_read_data(mem_read_data)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ext(input logic [31:0] w, input logic [1:0] size, input logic uns);
      case (size)
         2'b00:   ext = uns ? {24'h0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
         2'b01:   ext = uns ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
         2'b10:   ext = w;
         default: ext = 32'h0;
      endcase
   endfunction

   // Cycle counter: number of rising edges since reset released
   int cyc;
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   // ---------------- memory answering the DUT (256 bytes, wraps) ----------------
   logic [7:0]  sim_mem [256];
   logic [7:0]  ra, wa;
   logic [31:0] rword;

   always_comb begin
      ra            = mem_read_addr[7:0];
      rword         = {sim_mem[ra + 8'd3], sim_mem[ra + 8'd2], sim_mem[ra + 8'd1], sim_mem[ra]};
      mem_read_data = ext(rword, mem_size, mem_is_unsigned);
   end

   initial begin
      for (int i = 0; i < 256; i++) sim_mem[i] = 8'(i) ^ 8'h5A;
      forever begin
         @(posedge clk);
         if (mem_write_enable) begin
            wa = mem_write_addr[7:0];
            sim_mem[wa] = mem_write_data[7:0];
            if (mem_size != 2'b00) sim_mem[wa + 8'd1] = mem_write_data[15:8];
            if (mem_size == 2'b10) begin
               sim_mem[wa + 8'd2] = mem_write_data[23:16];
               sim_mem[wa + 8'd3] = mem_write_data[31:24];
            end
         end
      end
   end

   // ---------------- monitors ----------------
   typedef struct { int cyc; logic [31:0] d; logic e; } rsp_t;
   rsp_t q0[$];
   rsp_t q1[$];
   int   glog[$];
   int   we_cnt = 0;

   initial begin
      rsp_t r;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (p0_rsp_valid) begin r.cyc = cyc; r.d = p0_rdata; r.e = p0_rsp_err; q0.push_back(r); end
            if (p1_rsp_valid) begin r.cyc = cyc; r.d = p1_rdata; r.e = p1_rsp_err; q1.push_back(r); end
            if (p0_ready) glog.push_back(0);
            if (p1_ready) glog.push_back(1);
            if (mem_write_enable) we_cnt++;
         end
      end
   end

   // ---------------- transaction-level model and per-cycle compare ----------------
   typedef struct {
      int          port;
      logic [31:0] addr, wdata, rdata;
      logic        we, uns, err;
      logic [1:0]  size;
   } txn_t;

   logic [7:0] model_mem [256];

   function automatic logic [31:0] model_word(input logic [7:0] a);
      model_word = {model_mem[a + 8'd3], model_mem[a + 8'd2], model_mem[a + 8'd1], model_mem[a]};
   endfunction

   initial begin
      int   last_acc, wcnt;
      txn_t acc;
      logic in_access, in_resp, sel1, e0, e1;
      logic [7:0] ma;
      acc = '{port: 0, addr: 0, wdata: 0, rdata: 0, we: 0, uns: 0, err: 0, size: 0};
      for (int i = 0; i < 256; i++) model_mem[i] = 8'(i) ^ 8'h5A;
      last_acc = -100;
      wcnt     = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            last_acc = -100;
            wcnt     = 0;
            check("cmp_reset_ctl", {p0_ready, p1_ready, p0_rsp_valid, p1_rsp_valid,
                                    p0_rsp_err, p1_rsp_err, mem_write_enable, mem_size,
                                    mem_is_unsigned, p0_rdata, p1_rdata}, 0);
            check("cmp_reset_bus", {mem_read_addr, mem_write_addr, mem_write_data}, 0);
         end else begin
            in_access = (last_acc == cyc);
            in_resp   = (last_acc == cyc - 1);

            // The transaction in memory this cycle: resolve it against the reference memory
            if (in_access) begin
               ma = acc.addr[7:0];
               acc.err = (acc.size == 2'b11) || (acc.size == 2'b01 && acc.addr[0]) ||
                         (acc.size == 2'b10 && acc.addr[1:0] != 2'b00);
               acc.rdata = (acc.err || acc.we) ? 32'h0 : ext(model_word(ma), acc.size, acc.uns);
               if (acc.we && !acc.err) begin
                  model_mem[ma] = acc.wdata[7:0];
                  if (acc.size != 2'b00) model_mem[ma + 8'd1] = acc.wdata[15:8];
                  if (acc.size == 2'b10) begin
                     model_mem[ma + 8'd2] = acc.wdata[23:16];
                     model_mem[ma + 8'd3] = acc.wdata[31:24];
                  end
               end
               check("cmp_mem_bus",
                     {mem_read_addr, mem_write_addr, mem_write_data, mem_write_enable, mem_size, mem_is_unsigned},
                     {acc.addr, acc.addr, acc.wdata, acc.we && !acc.err, acc.size, acc.uns});
            end else begin
               check("cmp_mem_idle",
                     {mem_read_addr, mem_write_addr, mem_write_data, mem_write_enable, mem_size, mem_is_unsigned}, 0);
            end

            check("cmp_rsp_valid", {p0_rsp_valid, p1_rsp_valid},
                  {in_resp && acc.port == 0, in_resp && acc.port == 1});
            if (in_resp && acc.port == 0) check("cmp_p0_rsp", {p0_rdata, p0_rsp_err}, {acc.rdata, acc.err});
            if (in_resp && acc.port == 1) check("cmp_p1_rsp", {p1_rdata, p1_rsp_err}, {acc.rdata, acc.err});

            // Arbitration: at most one accept per two cycles, port 0 preferred
            sel1 = p1_req && (!p0_req || wcnt == MAX_WAIT);
            e1   = !in_access && sel1;
            e0   = !in_access && p0_req && !sel1;
            check("cmp_ready", {p0_ready, p1_ready}, {e0, e1});

            if (!p1_req || e1)               wcnt = 0;
            else if (e0 && wcnt < MAX_WAIT)  wcnt = wcnt + 1;

            if (e0 || e1) begin
               last_acc  = cyc + 1;
               acc.port  = e1 ? 1 : 0;
               acc.addr  = e1 ? p1_addr     : p0_addr;
               acc.wdata = e1 ? p1_wdata    : p0_wdata;
               acc.we    = e1 ? p1_we       : p0_we;
               acc.size  = e1 ? p1_size     : p0_size;
               acc.uns   = e1 ? p1_unsigned : p0_unsigned;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(input int port, input logic req, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic we, input logic [1:0] size, input logic uns);
      if (port == 0) begin
         p0_req = req; p0_addr = addr; p0_wdata = wdata; p0_we = we; p0_size = size; p0_unsigned = uns;
      end else begin
         p1_req = req; p1_addr = addr; p1_wdata = wdata; p1_we = we; p1_size = size; p1_unsigned = uns;
      end
   endtask

   task automatic wait_ready(input int port, output int a);
      bit ok;
      ok = 0;
      a  = -1;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if ((port == 0 && p0_ready) || (port == 1 && p1_ready)) begin
            ok = 1;
            a  = cyc;
            break;
         end
      end
      if (!ok) check("ready_timeout", 0, 1);
   endtask

   task automatic wait_rsp(input int port, output rsp_t r);
      bit ok;
      ok = 0;
      r.cyc = -1; r.d = 32'hX; r.e = 1'bX;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         #1;
         if (port == 0 && q0.size() > 0) begin r = q0.pop_front(); ok = 1; break; end
         if (port == 1 && q1.size() > 0) begin r = q1.pop_front(); ok = 1; break; end
      end
      if (!ok) check("rsp_timeout", 0, 1);
   endtask

   // One complete transaction: request, accept, release, collect the response
   task automatic txn(input int port, input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                      input logic [1:0] size, input logic uns, output rsp_t r, output int a);
      @(posedge clk); #1;
      drive(port, 1'b1, addr, wdata, we, size, uns);
      wait_ready(port, a);
      @(posedge clk); #1;
      drive(port, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
      wait_rsp(port, r);
   endtask

   // ---------------- directed tests ----------------
   initial begin
      rsp_t r;
      int   a, w0;
      int   rc [3];
      logic [31:0] addrs  [3] = '{32'h10, 32'h14, 32'h18};
      logic [31:0] exp_rd [3] = '{32'hDEADBEEF, 32'h4D4C4F4E, 32'h41404342};
      int   exp_g  [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

      rst = 1'b1;
      drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
      drive(1, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("reset_ready",  {p0_ready, p1_ready}, 2'b00);
      check("reset_rsp",    {p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err}, 4'b0000);
      check("reset_rdata",  {p0_rdata, p1_rdata}, 64'h0);
      check("reset_mem_we", mem_write_enable, 1'b0);
      #1 rst = 1'b0;

      // Store word then load it back
      w0 = we_cnt;
      txn(0, 32'h10, 32'hDEADBEEF, 1'b1, 2'b10, 1'b0, r, a);
      check("sw_rsp", {r.d, r.e}, {32'h0, 1'b0});
      check("sw_we_once", we_cnt - w0, 1);
      txn(0, 32'h10, 32'h0, 1'b0, 2'b10, 1'b0, r, a);
      check("lw_data", {r.d, r.e}, {32'hDEADBEEF, 1'b0});
      check("lw_latency", r.cyc, a + 2);

      // Byte sign/zero extension and illegal size
      txn(0, 32'h30, 32'h00000080, 1'b1, 2'b00, 1'b0, r, a);
      txn(0, 32'h30, 32'h0, 1'b0, 2'b00, 1'b0, r, a);
      check("lb_signed", {r.d, r.e}, {32'hFFFFFF80, 1'b0});
      txn(0, 32'h30, 32'h0, 1'b0, 2'b00, 1'b1, r, a);
      check("lbu", {r.d, r.e}, {32'h00000080, 1'b0});
      txn(0, 32'h30, 32'h0, 1'b0, 2'b11, 1'b0, r, a);
      check("size11_err", {r.d, r.e}, {32'h0, 1'b1});

      // Misaligned accesses on port 1 never touch memory
      w0 = we_cnt;
      txn(1, 32'h21, 32'h0, 1'b0, 2'b01, 1'b0, r, a);
      check("lh_misaligned", {r.d, r.e}, {32'h0, 1'b1});
      txn(1, 32'h22, 32'h12345678, 1'b1, 2'b10, 1'b0, r, a);
      check("sw_misaligned", {r.d, r.e}, {32'h0, 1'b1});
      check("misaligned_no_we", we_cnt - w0, 0);
      check("mem_20_23_intact", {sim_mem[8'h23], sim_mem[8'h22], sim_mem[8'h21], sim_mem[8'h20]}, 32'h79787B7A);

      // Back-to-back loads with req held: ready every second cycle
      q0.delete();
      @(posedge clk); #1;
      drive(0, 1'b1, addrs[0], 32'h0, 1'b0, 2'b10, 1'b0);
      for (int k = 0; k < 3; k++) begin
         wait_ready(0, rc[k]);
         @(posedge clk); #1;
         if (k < 2) drive(0, 1'b1, addrs[k + 1], 32'h0, 1'b0, 2'b10, 1'b0);
         else       drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
      end
      check("b2b_ready_gap1", rc[1] - rc[0], 2);
      check("b2b_ready_gap2", rc[2] - rc[0], 4);
      for (int k = 0; k < 3; k++) begin
         wait_rsp(0, r);
         check("b2b_rsp_cycle", r.cyc, rc[0] + 2 + 2 * k);
         check("b2b_rsp_data", {r.d, r.e}, {exp_rd[k], 1'b0});
      end

      // Contention: both ports hold requests
      glog.delete();
      @(posedge clk); #1;
      drive(0, 1'b1, 32'h10, 32'h0, 1'b0, 2'b10, 1'b0);
      drive(1, 1'b1, 32'h14, 32'h0, 1'b0, 2'b10, 1'b0);
      for (int n = 0; n < 80 && glog.size() < 10; n++) begin
         @(negedge clk); #1;
      end
      @(posedge clk); #1;
      drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
      drive(1, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
      check("grant_count", glog.size() >= 10, 1'b1);
      for (int k = 0; k < 10 && k < glog.size(); k++) check("grant_order", glog[k], exp_g[k]);
      repeat (6) @(negedge clk);
      q0.delete();
      q1.delete();

      // Async reset during the ACCESS cycle of a byte store
      @(posedge clk); #1;
      drive(0, 1'b1, 32'h40, 32'h11, 1'b1, 2'b00, 1'b0);
      wait_ready(0, a);
      @(posedge clk); #1;
      check("rst_we_before", mem_write_enable, 1'b1);
      #1 rst = 1'b1;
      drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
      #1;
      check("rst_we_async_drop", mem_write_enable, 1'b0);
      check("rst_ready_drop", {p0_ready, p1_ready, p0_rsp_valid}, 3'b000);
      @(posedge clk);
      @(posedge clk); #2 rst = 1'b0;
      repeat (6) @(negedge clk);
      #1;
      check("rst_no_rsp", q0.size() + q1.size(), 0);
      check("rst_byte_intact", sim_mem[8'h40], 8'h1A);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
